// File: rtl/nv_nvdla_sdp_wdma_pack_pkg.sv
// Shared types and helpers for the SDP write-DMA beat packer.
// Atom width, slot-counter sizing and the packed output bundle.
package nv_nvdla_sdp_wdma_pack_pkg;

   localparam int SDP_ATOM_DW     = 256;
   localparam int SDP_PACK_IN_DW  = 128;
   localparam int SDP_PACK_RATIO  = SDP_ATOM_DW / SDP_PACK_IN_DW;

   // Slot counter needs at least one bit even when a single beat fills an atom.
   function automatic int pack_cnt_w(input int ratio);
      return (ratio <= 2) ? 1 : $clog2(ratio);
   endfunction

   typedef struct packed {
      logic [SDP_ATOM_DW-1:0]    pd;
      logic [SDP_PACK_RATIO-1:0] mask;
   } pack_out_t;

endpackage

// File: rtl/nv_nvdla_sdp_wdma_pack.sv
// Packs IN_DW-wide SDP core beats into OUT_DW atoms for WDMA; a line-end flushes a zero-padded partial atom.
// 1-cycle commit-to-output latency; optional stall counter under NVDLA_SDP_WDMA_PACK_PERF_EN.
module nv_nvdla_sdp_wdma_pack
   import nv_nvdla_sdp_wdma_pack_pkg::*;
#(
   parameter int IN_DW  = SDP_PACK_IN_DW,
   parameter int OUT_DW = SDP_ATOM_DW
) (
   input  logic                      nvdla_core_clk,
   input  logic                      nvdla_core_rstn,
   input  logic                      op_load,
   input  logic                      dp2pack_valid,
   output logic                      dp2pack_ready,
   input  logic [IN_DW-1:0]          dp2pack_pd,
   input  logic                      dp2pack_last,
   output logic                      sdp_dp2wdma_valid,
   input  logic                      sdp_dp2wdma_ready,
   output logic [OUT_DW-1:0]         sdp_dp2wdma_pd,
   output logic [OUT_DW/IN_DW-1:0]   sdp_dp2wdma_mask,
   output logic [31:0]               pack_stall_cnt
);

   localparam int RATIO = OUT_DW / IN_DW;
   localparam int CW    = pack_cnt_w(RATIO);

   logic [CW-1:0]     cnt_q, cnt_d;
   logic [OUT_DW-1:0] acc_q, acc_d;
   logic [OUT_DW-1:0] out_pd_q, out_pd_d;
   logic [RATIO-1:0]  out_mask_q, out_mask_d;
   logic              out_vld_q, out_vld_d;

   logic              commit_beat;
   logic              accept;
   logic [OUT_DW-1:0] merged;
   logic [RATIO-1:0]  fill;

   always_comb begin
      commit_beat   = dp2pack_last | (cnt_q == CW'(RATIO - 1));
      dp2pack_ready = !out_vld_q | sdp_dp2wdma_ready | !commit_beat;
      // A beat offered alongside op_load belongs to the old layer and is dropped.
      accept        = dp2pack_valid & dp2pack_ready & !op_load;

      // Slots above cnt are still zero in acc, which gives the padding for free.
      merged = acc_q;
      fill   = '0;
      for (int s = 0; s < RATIO; s++) begin
         if (CW'(s) == cnt_q) begin
            merged[s*IN_DW +: IN_DW] = dp2pack_pd;
         end
         fill[s] = (CW'(s) <= cnt_q);
      end

      cnt_d = cnt_q;
      acc_d = acc_q;
      if (op_load) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (accept) begin
         if (commit_beat) begin
            cnt_d = '0;
            acc_d = '0;
         end else begin
            cnt_d = cnt_q + CW'(1);
            acc_d = merged;
         end
      end

      out_pd_d   = out_pd_q;
      out_mask_d = out_mask_q;
      out_vld_d  = out_vld_q;
      if (accept && commit_beat) begin
         out_pd_d   = merged;
         out_mask_d = fill;
         out_vld_d  = 1'b1;
      end else if (sdp_dp2wdma_ready) begin
         out_vld_d  = 1'b0;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         out_pd_q   <= '0;
         out_mask_q <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         out_pd_q   <= out_pd_d;
         out_mask_q <= out_mask_d;
         out_vld_q  <= out_vld_d;
      end
   end

   assign sdp_dp2wdma_valid = out_vld_q;
   assign sdp_dp2wdma_pd    = out_pd_q;
   assign sdp_dp2wdma_mask  = out_mask_q;

`ifdef NVDLA_SDP_WDMA_PACK_PERF_EN
   logic [31:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (op_load) begin
         stall_d = '0;
      end else if (out_vld_q && !sdp_dp2wdma_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign pack_stall_cnt = stall_q;
`else
   assign pack_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_sdp_wdma_pack.sv
// Directed bench for the WDMA beat packer (IN_DW=128, OUT_DW=256): vector table plus corner sequences.
module tb_nv_nvdla_sdp_wdma_pack;
   import nv_nvdla_sdp_wdma_pack_pkg::*;

   logic         clk;
   logic         rstn;
   logic         op_load;
   logic         in_vld;
   logic         in_rdy;
   logic [127:0] in_pd;
   logic         in_last;
   logic         out_vld;
   logic         out_rdy;
   logic [255:0] out_pd;
   logic [1:0]   out_mask;
   logic [31:0]  stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   nv_nvdla_sdp_wdma_pack #(.IN_DW(128), .OUT_DW(256)) dut (
      .nvdla_core_clk    (clk),
      .nvdla_core_rstn   (rstn),
      .op_load           (op_load),
      .dp2pack_valid     (in_vld),
      .dp2pack_ready     (in_rdy),
      .dp2pack_pd        (in_pd),
      .dp2pack_last      (in_last),
      .sdp_dp2wdma_valid (out_vld),
      .sdp_dp2wdma_ready (out_rdy),
      .sdp_dp2wdma_pd    (out_pd),
      .sdp_dp2wdma_mask  (out_mask),
      .pack_stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [7:0] id;
      logic       last;
      logic       ordy;
      logic       load;
      logic       exp_irdy;
      logic       exp_ovld;
      logic [7:0] hi;
      logic [7:0] lo;
      logic [1:0] mask;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [127:0] beat(input logic [7:0] id);
      return {16{id}};
   endfunction

   function automatic vec_t v(input logic vld, input logic [7:0] id, input logic last,
                              input logic ordy, input logic load, input logic exp_irdy,
                              input logic exp_ovld, input logic [7:0] hi, input logic [7:0] lo,
                              input logic [1:0] mask);
      vec_t r;
      r.vld = vld; r.id = id; r.last = last; r.ordy = ordy; r.load = load;
      r.exp_irdy = exp_irdy; r.exp_ovld = exp_ovld; r.hi = hi; r.lo = lo; r.mask = mask;
      return r;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [7:0] id, input logic last,
                        input logic ordy, input logic load);
      in_vld  = vld;
      in_pd   = vld ? beat(id) : '0;
      in_last = last;
      out_rdy = ordy;
      op_load = load;
   endtask

   task automatic apply(input vec_t t, input int idx);
      pack_out_t e;
      @(negedge clk);
      drive(t.vld, t.id, t.last, t.ordy, t.load);
      #1;
      chk($sformatf("row%0d in_rdy", idx), 256'(in_rdy), 256'(t.exp_irdy));
      chk($sformatf("row%0d out_vld", idx), 256'(out_vld), 256'(t.exp_ovld));
      if (t.exp_ovld) begin
         e.pd   = {beat(t.hi), beat(t.lo)};
         e.mask = t.mask;
         chk($sformatf("row%0d pd", idx), out_pd, e.pd);
         chk($sformatf("row%0d mask", idx), 256'(out_mask), 256'(e.mask));
      end
   endtask

   initial begin
      int atoms;
      logic [31:0] exp_stall;

      rstn = 1'b0;
      drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);

      // vld id last ordy load | irdy ovld hi lo mask
      // Four full beats -> {B,A}, {D,C}
      vecs.push_back(v(1, 1, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 2, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 3, 0, 1, 0, 1, 1, 2, 1, 3));
      vecs.push_back(v(1, 4, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 4, 3, 3));
      // Line end on third beat -> {0,G} mask 01, then packing restarts at slot 0
      vecs.push_back(v(1, 5, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 6, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 7, 1, 1, 0, 1, 1, 6, 5, 3));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 0, 7, 1));
      vecs.push_back(v(1, 8, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 9, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 9, 8, 3));
      // Five-cycle output stall with a full atom pending
      vecs.push_back(v(1, 10, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 11, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 12, 0, 0, 0, 1, 1, 11, 10, 3));
      for (int i = 0; i < 4; i++)
         vecs.push_back(v(1, 13, 0, 0, 0, 0, 1, 11, 10, 3));
      vecs.push_back(v(1, 13, 0, 1, 0, 1, 1, 11, 10, 3));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 13, 12, 3));
      // op_load at cnt=1 discards P; pending {O,N} still drains
      vecs.push_back(v(1, 14, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 15, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 16, 0, 0, 0, 1, 1, 15, 14, 3));
      vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 15, 14, 3));
      vecs.push_back(v(1, 17, 0, 1, 0, 1, 1, 15, 14, 3));
      vecs.push_back(v(1, 18, 0, 1, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 1, 18, 17, 3));
      vecs.push_back(v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));

      #12;
      chk("reset out_vld", 256'(out_vld), 256'd0);
      chk("reset pd", out_pd, 256'd0);
      chk("reset mask", 256'(out_mask), 256'd0);
      chk("reset stall_cnt", 256'(stall_cnt), 256'd0);
      chk("reset in_rdy", 256'(in_rdy), 256'd1);
      @(negedge clk);
      rstn = 1'b1;

      foreach (vecs[i]) apply(vecs[i], i);

      // 64 back-to-back beats -> 32 atoms within 65 cycles
      atoms = 0;
      for (int c = 0; c <= 64; c++) begin
         @(negedge clk);
         drive(c < 64, 8'(c + 1), 1'b0, 1'b1, 1'b0);
         #1;
         if (c < 64) chk($sformatf("stream c%0d in_rdy", c), 256'(in_rdy), 256'd1);
         chk($sformatf("stream c%0d out_vld", c), 256'(out_vld), 256'((c >= 2) && (c % 2 == 0)));
         if (out_vld) begin
            chk($sformatf("stream atom%0d pd", atoms), out_pd,
                {beat(8'(2 * atoms + 2)), beat(8'(2 * atoms + 1))});
            atoms++;
         end
      end
      chk("stream atom count", 256'(atoms), 256'd32);

      // Stall counter: clear, 7 stalled cycles, clear again while still stalled
`ifdef NVDLA_SDP_WDMA_PACK_PERF_EN
      exp_stall = 32'd7;
`else
      exp_stall = 32'd0;
`endif
      @(negedge clk); drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
      @(negedge clk); drive(1'b1, 8'd21, 1'b0, 1'b1, 1'b0);
      @(negedge clk); drive(1'b1, 8'd22, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      end
      @(negedge clk); drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
      #1;
      chk("stall_cnt after 7", 256'(stall_cnt), 256'(exp_stall));
      chk("stalled atom pd", out_pd, {beat(8'd22), beat(8'd21)});
      @(negedge clk); drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
      #1;
      chk("stall_cnt after op_load", 256'(stall_cnt), 256'd0);
      chk("stalled atom still valid", 256'(out_vld), 256'd1);

      // Asynchronous reset with an atom pending clears outputs immediately
      @(negedge clk); drive(1'b1, 8'd31, 1'b0, 1'b1, 1'b0);
      @(negedge clk); drive(1'b1, 8'd32, 1'b0, 1'b1, 1'b0);
      @(negedge clk); drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("pre-reset out_vld", 256'(out_vld), 256'd1);
      rstn = 1'b0;
      #1;
      chk("async reset out_vld", 256'(out_vld), 256'd0);
      chk("async reset pd", out_pd, 256'd0);
      chk("async reset mask", 256'(out_mask), 256'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
